aes_inv_cipher_iter: RTL and testbench

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_inv_cipher_iter.sv | 136 +++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, GF(2^8) arithmetic, S-boxes and key-schedule steps.
`default_nettype none

package aes_pkg;

    localparam int NR_DEFAULT = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_FINAL = 8'h6c;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime, used to walk rcon backwards.
    function automatic logic [7:0] gf_half(input logic [7:0] b);
        return b[0] ? (({1'b0, b[7:1]} ^ 8'h0d) | 8'h80) : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            res = gmul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rc is the constant that produced k from its predecessor.
    function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0] b [16];
    logic [7:0] o [16];

    always_comb begin
        // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r.
        for (int i = 0; i < 16; i++) begin
            b[i] = inv_sbox(state_in[127 - 8 * ((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)) -: 8])
                   ^ round_key[127 - 8 * i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) o[4 * c + r] = b[4 * c + r];
            end else begin
                o[4*c]   = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
                o[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
                o[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
                o[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign state_out[127 - 8 * i -: 8] = o[i];
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: expands the key forward, then runs ten inverse rounds.
// Optional AES_INV_KEYCACHE_EN retains the last key/K10 pair to skip expansion on a repeat key.
`default_nettype none

module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher_iter: only NR=10 is supported");
    end

    state_t       state;
    logic [127:0] data;
    logic [127:0] key_r;
    logic [7:0]   rcon;
    logic [3:0]   cnt;

    logic [127:0] key_next;
    logic [127:0] key_prev;
    logic [7:0]   rcon_prev;
    logic [127:0] round_out;
    logic         cache_hit;
    logic [127:0] cached_k10;

    assign rcon_prev = gf_half(rcon);
    assign key_next  = key_fwd(key_r, rcon);
    assign key_prev  = key_bwd(key_r, rcon_prev);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign pt        = data;

    aes_inv_round u_round (
        .state_in  (data),
        .round_key (key_prev),
        .last      (cnt == 4'd0),
        .state_out (round_out)
    );

`ifdef AES_INV_KEYCACHE_EN
    logic         cache_vld;
    logic [127:0] cache_key;
    logic [127:0] cache_k10;

    assign cache_hit  = cache_vld && (key == cache_key);
    assign cached_k10 = cache_k10;

    // The cache is invalidated on a miss so an aborted expansion never leaves a stale pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_key <= '0;
            cache_k10 <= '0;
        end else if (state == IDLE && in_valid && !cache_hit) begin
            cache_vld <= 1'b0;
            cache_key <= key;
        end else if (state == KEYEXP && cnt == 4'd9) begin
            cache_vld <= 1'b1;
            cache_k10 <= key_next;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cached_k10 = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            key_r <= '0;
            rcon  <= RCON_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (cache_hit) begin
                            key_r <= cached_k10;
                            data  <= ct ^ cached_k10;
                            rcon  <= RCON_FINAL;
                            cnt   <= 4'(NR - 1);
                            state <= ROUND;
                        end else begin
                            key_r <= key;
                            data  <= ct;
                            rcon  <= RCON_INIT;
                            cnt   <= '0;
                            state <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    key_r <= key_next;
                    rcon  <= xtime(rcon);
                    if (cnt == 4'(NR - 1)) begin
                        data  <= data ^ key_next;
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    key_r <= key_prev;
                    rcon  <= rcon_prev;
                    data  <= round_out;
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors.
`default_nettype none

module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] pt;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_INV_KEYCACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accepts one job, toggles junk input while busy, and leaves the DUT in DONE.
    task automatic start_job(input logic [127:0] k, input logic [127:0] c, input string tag, output int lat);
        logic busy_ready;
        busy_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        ct       = c;
        key      = k;
        @(posedge clk);
        #1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom % 2);
            ct       = rnd128();
            key      = rnd128();
            busy_ready = busy_ready | in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_busy_ready"}, 128'(busy_ready), 128'd0);
    endtask

    task automatic run_job(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                           input int exp_lat, input string tag);
        int lat;
        start_job(k, c, tag, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_pt"}, pt, p);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 128'({in_ready, out_valid}), 128'b10);
    endtask

    initial begin
        int lat;
        int seen;
        #12;
        check("rst_ready", 128'(in_ready), 128'd1);
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_pt", pt, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(KEY1, CT1, PT1, 20, "job1");

        // Output stall: result must hold while the consumer is not ready.
        start_job(KEY2, CT2, "job2", lat);
        check("job2_lat", 128'(lat), 128'd20);
        check("job2_pt", pt, PT2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall", {pt[124:0], out_valid, in_ready, 1'b0}, {PT2[124:0], 1'b1, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release", 128'({in_ready, out_valid}), 128'b10);

        run_job(KEY2, CT2, PT2, HIT_LAT, "job3_samekey");

        // Abort mid-job with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        ct       = CT1;
        key      = KEY1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(out_valid), 128'd0);
        check("abort_pt", pt, 128'd0);
        check("abort_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 128'(seen), 128'd0);

        // Reset clears any cached key, so the same key pays full latency again.
        run_job(KEY2, CT2, PT2, 20, "job4_postrst");
        run_job(KEY1, CT1, PT1, 20, "job5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
